// File: rtl/tx_word_streamer.sv
// rtl/tx_word_streamer.sv - streams buffer words out to the tx FIFO as bytes, low byte first
//
// Reads a run of consecutive words from the unified buffer and pushes each one into the
// tx FIFO as two bytes, low byte first. At the end it pulses done and tx_kick together so
// the UART starts draining.
//
// Ports:
//   clk, rst        clock (rising edge); synchronous active-high reset
//   i_start         one-cycle request; only taken while idle
//   i_base_addr     first word address, latched when a start is taken
//   i_word_count    number of words to send, latched when a start is taken
//   o_busy          high in every state except idle
//   o_done          one-cycle pulse at the end of a transfer
//   o_tx_kick       one-cycle pulse, same cycle as o_done
//   o_mem_re        buffer read strobe, one cycle per word
//   o_mem_addr      buffer read address; keeps its last value between reads
//   i_mem_rdata     buffer read data, valid READ_LATENCY cycles after o_mem_re
//   o_fifo_we       tx FIFO write strobe (never asserted while i_fifo_full)
//   o_fifo_wdata    tx FIFO write data
//   i_fifo_full     tx FIFO full flag
module tx_word_streamer #(
  parameter int BUFFER_WORD_SIZE = 16,
  parameter int FIFO_DATA_WIDTH  = 8,
  parameter int ADDRESS_SIZE     = 9,
  parameter int LEN_WIDTH        = 10,
  parameter int READ_LATENCY     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [ADDRESS_SIZE-1:0]     i_base_addr,
  input  logic [LEN_WIDTH-1:0]        i_word_count,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_tx_kick,
  output logic                        o_mem_re,
  output logic [ADDRESS_SIZE-1:0]     o_mem_addr,
  input  logic [BUFFER_WORD_SIZE-1:0] i_mem_rdata,
  output logic                        o_fifo_we,
  output logic [FIFO_DATA_WIDTH-1:0]  o_fifo_wdata,
  input  logic                        i_fifo_full
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  // The wait counter is loaded with this and counts down; data is captured when it hits zero.
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND_LO,
    S_SEND_HI,
    S_DONE
  } state_t;

  state_t                      r_state;
  logic [ADDRESS_SIZE-1:0]     r_cur_addr;
  logic [LEN_WIDTH-1:0]        r_remaining;
  logic [CNT_W-1:0]            r_wait_cnt;
  logic [FIFO_DATA_WIDTH-1:0]  r_hi_byte;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_tx_kick;
  logic                        r_mem_re;
  logic [ADDRESS_SIZE-1:0]     r_mem_addr;
  logic [FIFO_DATA_WIDTH-1:0]  r_fifo_wdata;

  logic                        w_in_send;
  logic                        w_write;
  logic [ADDRESS_SIZE-1:0]     w_next_addr;

  assign w_in_send   = (r_state == S_SEND_LO) || (r_state == S_SEND_HI);
  // The write strobe follows the full flag in the same cycle so a byte goes out as soon
  // as there is room; the byte itself is held in r_fifo_wdata until it is accepted.
  assign w_write     = w_in_send && !i_fifo_full;
  assign w_next_addr = r_cur_addr + 1'b1;  // wraps at the top of the buffer

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_tx_kick    = r_tx_kick;
  assign o_mem_re     = r_mem_re;
  assign o_mem_addr   = r_mem_addr;
  assign o_fifo_we    = w_write;
  assign o_fifo_wdata = r_fifo_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_remaining  <= '0;
      r_wait_cnt   <= '0;
      r_hi_byte    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_tx_kick    <= 1'b0;
      r_mem_re     <= 1'b0;
      r_mem_addr   <= '0;
      r_fifo_wdata <= '0;
    end else begin
      // Strobes are single-cycle; they are only set on the transition into their state.
      r_mem_re  <= 1'b0;
      r_done    <= 1'b0;
      r_tx_kick <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cur_addr  <= i_base_addr;
            r_remaining <= i_word_count;
            r_busy      <= 1'b1;
            if (i_word_count == '0) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_tx_kick <= 1'b1;
            end else begin
              r_state    <= S_READ;
              r_mem_re   <= 1'b1;
              r_mem_addr <= i_base_addr;
            end
          end
        end

        S_READ: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= LAT_LAST;
        end

        S_WAIT: begin
          if (r_wait_cnt == '0) begin
            // Low byte goes straight to the output register; high byte is parked.
            r_fifo_wdata <= i_mem_rdata[FIFO_DATA_WIDTH-1:0];
            r_hi_byte    <= i_mem_rdata[2*FIFO_DATA_WIDTH-1:FIFO_DATA_WIDTH];
            r_state      <= S_SEND_LO;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end

        S_SEND_LO: begin
          if (w_write) begin
            r_fifo_wdata <= r_hi_byte;
            r_state      <= S_SEND_HI;
          end
        end

        S_SEND_HI: begin
          if (w_write) begin
            r_remaining <= r_remaining - 1'b1;
            r_cur_addr  <= w_next_addr;
            if (r_remaining == LEN_WIDTH'(1)) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_tx_kick <= 1'b1;
            end else begin
              r_state    <= S_READ;
              r_mem_re   <= 1'b1;
              r_mem_addr <= w_next_addr;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_word_streamer.sv
// tb/tb_tx_word_streamer.sv - self-checking bench for tx_word_streamer
module tb_tx_word_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // DUT with READ_LATENCY=1
  logic        rst1 = 1'b1, start1 = 1'b0, full1 = 1'b0;
  logic [8:0]  base1 = '0;
  logic [9:0]  cnt1 = '0;
  logic        busy1, done1, kick1, re1, we1;
  logic [8:0]  maddr1;
  logic [15:0] rdata1 = '0;
  logic [7:0]  wdata1;

  // DUT with READ_LATENCY=3
  logic        rst3 = 1'b1, start3 = 1'b0, full3 = 1'b0;
  logic [8:0]  base3 = '0;
  logic [9:0]  cnt3 = '0;
  logic        busy3, done3, kick3, re3, we3;
  logic [8:0]  maddr3;
  logic [15:0] rdata3 = '0;
  logic [7:0]  wdata3;

  tx_word_streamer #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst1), .i_start(start1), .i_base_addr(base1), .i_word_count(cnt1),
    .o_busy(busy1), .o_done(done1), .o_tx_kick(kick1), .o_mem_re(re1), .o_mem_addr(maddr1),
    .i_mem_rdata(rdata1), .o_fifo_we(we1), .o_fifo_wdata(wdata1), .i_fifo_full(full1)
  );

  tx_word_streamer #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst3), .i_start(start3), .i_base_addr(base3), .i_word_count(cnt3),
    .o_busy(busy3), .o_done(done3), .o_tx_kick(kick3), .o_mem_re(re3), .o_mem_addr(maddr3),
    .i_mem_rdata(rdata3), .o_fifo_we(we3), .o_fifo_wdata(wdata3), .i_fifo_full(full3)
  );

  // Buffer model: one shared array, separate read pipelines per latency.
  logic [15:0] mem [0:511];
  logic [15:0] p0 = '0, p1 = '0;
  always @(posedge clk) if (re1) rdata1 <= mem[maddr1];
  always @(posedge clk) begin
    p0     <= mem[maddr3];
    p1     <= p0;
    rdata3 <= p1;
  end

  // Output monitors (sampled on the falling edge).
  logic [7:0] obs1[$], obs3[$];
  logic [8:0] adr1[$], adr3[$];
  int n_done1 = 0, done_cyc1 = -1, kick_cyc1 = -2, n_wfull1 = 0;
  int n_done3 = 0, done_cyc3 = -1, kick_cyc3 = -2, n_re3 = 0;
  always @(negedge clk) begin
    if (we1) begin obs1.push_back(wdata1); if (full1) n_wfull1++; end
    if (re1) adr1.push_back(maddr1);
    if (done1) begin n_done1++; done_cyc1 = cyc; end
    if (kick1) kick_cyc1 = cyc;
    if (we3) obs3.push_back(wdata3);
    if (re3) begin n_re3++; adr3.push_back(maddr3); end
    if (done3) begin n_done3++; done_cyc3 = cyc; end
    if (kick3) kick_cyc3 = cyc;
  end

  // Scoreboard queues of expected bytes/addresses and read pointers into the observed ones.
  logic [7:0] exp_b[$];
  logic [8:0] exp_a[$];
  int rd_b1 = 0, rd_a1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run1(input string tag, input logic [8:0] base, input int count,
                      input int fs, input int fl, input int rst_word, input int exp_done,
                      input bit rnd_full, input bit restart);
    int d0, s, rst_at, nwords, nreads, nb;
    bit seen_done;
    logic [15:0] w;
    logic [8:0] a;
    rst_at = (rst_word >= 0) ? 4 * rst_word + 3 : -1;
    nwords = (rst_word >= 0) ? rst_word : count;
    nreads = (rst_word >= 0) ? rst_word + 1 : count;
    for (int i = 0; i < nwords; i++) begin
      a = base + 9'(i);
      w = mem[a];
      exp_b.push_back(w[7:0]);
      exp_b.push_back(w[15:8]);
    end
    for (int i = 0; i < nreads; i++) exp_a.push_back(base + 9'(i));
    @(posedge clk); #1;
    d0 = n_done1;
    s = cyc;
    seen_done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      start1 = (c == 0) || (restart && (c == 2 || c == 6));
      base1  = (c == 0) ? base : 9'h155;
      cnt1   = (c == 0) ? 10'(count) : 10'd7;
      full1  = rnd_full ? ($urandom_range(0, 2) == 0) : (c >= fs && c < fs + fl);
      if (c == rst_at) full1 = 1'b1;
      rst1 = (c == rst_at);
      @(posedge clk); #1;
      if (c == rst_at) chk({tag, "_busy_after_rst"}, 32'(busy1), 32'd0);
      if (n_done1 != d0) begin seen_done = 1'b1; break; end
      if (rst_at >= 0 && c == rst_at + 20) break;
    end
    start1 = 1'b0; full1 = 1'b0; rst1 = 1'b0;
    if (rst_at < 0) begin
      chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
      if (exp_done >= 0) chk({tag, "_done_cycle"}, 32'(done_cyc1 - s), 32'(exp_done));
      chk({tag, "_kick_cycle"}, 32'(kick_cyc1), 32'(done_cyc1));
    end else begin
      chk({tag, "_no_done"}, 32'(seen_done), 32'd0);
    end
    nb = obs1.size() - rd_b1;
    chk({tag, "_nbytes"}, 32'(nb), 32'(exp_b.size()));
    while (exp_b.size() > 0 && rd_b1 < obs1.size()) begin
      chk($sformatf("%s_byte%0d", tag, rd_b1), 32'(obs1[rd_b1]), 32'(exp_b.pop_front()));
      rd_b1++;
    end
    exp_b.delete();
    rd_b1 = obs1.size();
    nb = adr1.size() - rd_a1;
    chk({tag, "_nreads"}, 32'(nb), 32'(exp_a.size()));
    while (exp_a.size() > 0 && rd_a1 < adr1.size()) begin
      chk($sformatf("%s_addr%0d", tag, rd_a1), 32'(adr1[rd_a1]), 32'(exp_a.pop_front()));
      rd_a1++;
    end
    exp_a.delete();
    rd_a1 = adr1.size();
  endtask

  initial begin
    int s3;
    logic [7:0] e3[$];
    logic [15:0] w;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    mem[9'h010] = 16'hA1B2;
    mem[9'h011] = 16'hC3D4;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_kick", 32'(kick1), 32'd0);
    chk("rst_mem_re", 32'(re1), 32'd0);
    chk("rst_fifo_we", 32'(we1), 32'd0);
    chk("rst_mem_addr", 32'(maddr1), 32'd0);
    chk("rst_fifo_wdata", 32'(wdata1), 32'd0);
    rst1 = 1'b0;
    rst3 = 1'b0;

    //    tag    base    cnt fs fl rstw done rnd rstart
    run1("t1",  9'h010,  2,  -1, 0, -1,  9,  0, 0);
    run1("t2",  9'h030,  0,  -1, 0, -1,  1,  0, 0);
    run1("t3",  9'h010,  1,   4, 3, -1,  8,  0, 0);
    run1("t4",  9'h1FF,  2,  -1, 0, -1,  9,  0, 0);
    run1("t5",  9'h040,  4,  -1, 0,  1, -1,  0, 0);
    run1("t5b", 9'h040,  1,  -1, 0, -1,  5,  0, 0);
    run1("t6a", 9'h080,  3,  -1, 0, -1, 13,  0, 1);
    run1("t7",  9'h100,  6,  -1, 0, -1, -1,  1, 0);
    chk("write_while_full", 32'(n_wfull1), 32'd0);

    // READ_LATENCY=3 instance with start re-pulsed while busy.
    for (int i = 0; i < 3; i++) begin
      w = mem[9'h020 + 9'(i)];
      e3.push_back(w[7:0]);
      e3.push_back(w[15:8]);
    end
    @(posedge clk); #1;
    s3 = cyc;
    for (int c = 0; c < 200; c++) begin
      start3 = (c == 0) || (c == 3) || (c == 10);
      base3  = (c == 0) ? 9'h020 : 9'h0AA;
      cnt3   = (c == 0) ? 10'd3 : 10'd9;
      @(posedge clk); #1;
      if (n_done3 != 0) break;
    end
    start3 = 1'b0;
    chk("t6_done_seen", 32'(n_done3), 32'd1);
    chk("t6_done_cycle", 32'(done_cyc3 - s3), 32'd19);
    chk("t6_kick_cycle", 32'(kick_cyc3), 32'(done_cyc3));
    chk("t6_nreads", 32'(n_re3), 32'd3);
    chk("t6_nbytes", 32'(obs3.size()), 32'(e3.size()));
    for (int i = 0; i < obs3.size() && e3.size() > 0; i++)
      chk($sformatf("t6_byte%0d", i), 32'(obs3[i]), 32'(e3.pop_front()));
    for (int i = 0; i < adr3.size(); i++)
      chk($sformatf("t6_addr%0d", i), 32'(adr3[i]), 32'(9'h020 + 9'(i)));
    @(posedge clk); #1;
    chk("t6_busy_end", 32'(busy3), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
